// File: rtl/cdc_handshake_tx.sv
// Transmitter end of a four-phase req/ack clock-domain crossing. Captures one word,
// holds it on data_out and walks req_out through the handshake against a resynchronized ack.
module cdc_handshake_tx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_async,
  output logic             xfer_done,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax      = '1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic                   tout_q, tout_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_sync;
  logic                   waiting;

  // SYNC_STAGES must be at least 2; the chain is the only consumer of ack_async.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], ack_async};
  assign ack_sync = sync_q[SYNC_STAGES-1];
  assign waiting  = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tout_d  = tout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = StReqHi;
        end
      end
      StReqHi: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Counter restarts on every state change and saturates instead of wrapping.
    if (!waiting || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end

    if ((TIMEOUT != 0) && waiting && (state_d == state_q) && (cnt_q >= TimeoutLast)) begin
      tout_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
    end
  end

  assign in_ready    = (state_q == StIdle) && !reset;
  assign req_out     = req_q;
  assign data_out    = data_q;
  assign xfer_done   = done_q;
  assign busy        = waiting;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed handshakes with a queue-based scoreboard that
// checks the word presented at each req rise and at each xfer_done pulse.
module tb_cdc_handshake_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_async;
  logic       xfer_done;
  logic       busy;
  logic       timeout_err;

  logic auto_ack = 1'b0;
  logic ack_auto = 1'b0;
  logic ack_man  = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;

  logic [7:0] exp_req[$];
  logic [7:0] exp_done[$];

  always #5 clock = ~clock;

  assign ack_async = auto_ack ? ack_auto : ack_man;

  cdc_handshake_tx #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .TIMEOUT    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_async  (ack_async),
    .xfer_done  (xfer_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Far end that echoes req back one cycle later.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      ack_auto = req_out;
    end
  end

  // Scoreboard monitor.
  initial begin
    logic       req_prev = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (req_out && !req_prev) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req", {31'd0, req_out}, 32'd0);
        end else begin
          e = exp_req.pop_front();
          cur = e;
          check("req_data", {24'd0, data_out}, {24'd0, e});
        end
      end else if (busy) begin
        check("data_hold", {24'd0, data_out}, {24'd0, cur});
      end
      if (xfer_done) begin
        done_seen++;
        check("done_single_cycle", {31'd0, done_prev}, 32'd0);
        if (exp_done.size() == 0) begin
          check("unexpected_done", {31'd0, xfer_done}, 32'd0);
        end else begin
          e = exp_done.pop_front();
          check("done_data", {24'd0, data_out}, {24'd0, e});
        end
      end
      req_prev  = req_out;
      done_prev = xfer_done;
    end
  end

  // Offer d; return at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input bit expect_done);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("send_ready_timeout", 32'd0, 32'd1);
    end else begin
      exp_req.push_back(d);
      if (expect_done) exp_done.push_back(d);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 200) begin
      tick();
      n++;
    end
    check("done_count", done_seen, target);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ack_man  = 1'b1;

    // Reset with ack held high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end
    check("reset_req", {31'd0, req_out}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'd0);
    check("reset_tout", {31'd0, timeout_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Single transfer, cycle-exact.
    send(8'hA5, 1'b1);
    check("single_req_hi", {31'd0, req_out}, 32'd1);
    check("single_data", {24'd0, data_out}, 32'hA5);
    tick();
    ack_man = 1'b1;
    tick();
    tick();
    check("single_req_still_hi", {31'd0, req_out}, 32'd1);
    tick();
    check("single_req_fall", {31'd0, req_out}, 32'd0);
    tick();
    ack_man = 1'b0;
    tick();
    tick();
    check("single_no_done_yet", {31'd0, xfer_done}, 32'd0);
    check("single_busy_lo_wait", {31'd0, busy}, 32'd1);
    tick();
    check("single_done_pulse", {31'd0, xfer_done}, 32'd1);
    check("single_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("single_done_end", {31'd0, xfer_done}, 32'd0);
    check("single_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with auto-responding far end.
    auto_ack = 1'b1;
    begin
      int n;
      int base;
      base = done_seen;
      in_valid = 1'b1;
      in_data  = 8'h11;
      exp_req.push_back(8'h11);
      exp_done.push_back(8'h11);
      tick();
      in_data = 8'h22;
      n = 0;
      while (!in_ready && n < 100) begin
        check("b2b_hold_11", {24'd0, data_out}, 32'h11);
        tick();
        n++;
      end
      check("b2b_pulse_at_accept", {31'd0, xfer_done}, 32'd1);
      check("b2b_data_before_22", {24'd0, data_out}, 32'h11);
      exp_req.push_back(8'h22);
      exp_done.push_back(8'h22);
      tick();
      in_valid = 1'b0;
      wait_done(base + 2);
      for (int i = 0; i < 4; i++) tick();
      check("b2b_exactly_two", done_seen, base + 2);
      check("b2b_last_data", {24'd0, data_out}, 32'h22);
    end
    auto_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Stale ack already high before acceptance.
    ack_man = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    send(8'h5A, 1'b1);
    check("stale_req_hi", {31'd0, req_out}, 32'd1);
    tick();
    check("stale_req_lo", {31'd0, req_out}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("stale_still_busy", {31'd0, busy}, 32'd1);
    check("stale_no_done", {31'd0, xfer_done}, 32'd0);
    ack_man = 1'b0;
    tick();
    tick();
    check("stale_no_done_yet", {31'd0, xfer_done}, 32'd0);
    tick();
    check("stale_done", {31'd0, xfer_done}, 32'd1);
    check("stale_no_tout", {31'd0, timeout_err}, 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // Timeout: no ack for a long time.
    send(8'h77, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("tout_not_yet", {31'd0, timeout_err}, 32'd0);
    tick();
    check("tout_set", {31'd0, timeout_err}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("tout_sticky", {31'd0, timeout_err}, 32'd1);
    check("tout_still_waiting", {31'd0, req_out}, 32'd1);
    ack_man = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("tout_req_fall", {31'd0, req_out}, 32'd0);
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("tout_done", {31'd0, xfer_done}, 32'd1);
    check("tout_sticky_after", {31'd0, timeout_err}, 32'd1);
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-handshake, then a fresh transfer.
    begin
      int base;
      base = done_seen;
      send(8'h99, 1'b0);
      tick();
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      check("mid_req_dropped", {31'd0, req_out}, 32'd0);
      check("mid_busy_dropped", {31'd0, busy}, 32'd0);
      check("mid_no_done", {31'd0, xfer_done}, 32'd0);
      check("mid_tout_cleared", {31'd0, timeout_err}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid_no_stray_done", done_seen, base);
      auto_ack = 1'b1;
      send(8'h3C, 1'b1);
      wait_done(base + 1);
      auto_ack = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("fresh_data", {24'd0, data_out}, 32'h3C);
    end

    check("req_queue_empty", exp_req.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
